c_crc_check_seq: RTL and testbench

Multi-cycle CRC checker for flit-serialized frames on the receive side of a link. It folds each incoming data flit into a running CRC using a GF(2) next-state transform. On the tail flit it compares the result against the transmitted CRC and reports pass/fail plus framing violations. It is the checking counterpart of the matrix-based CRC generation used on the transmit path, and sits between the link deserializer and the input buffer.

---
 rtl/c_crc_pkg.sv | 47 ++++
 rtl/c_crc_step.sv | 27 ++
 rtl/c_crc_check_seq.sv | 103 ++++++++++
 tb/tb_c_crc_check_seq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c_crc_pkg.sv
// Shared CRC definitions: FSM state type, CRC-16/CCITT defaults and the
// constant GF(2) step-matrix builder used by the combinational step transform.
package c_crc_pkg;

    typedef enum logic {IDLE, BUSY} crc_state_e;

    localparam logic [15:0] CRC_POLY_CCITT = 16'h1021;
    localparam logic [15:0] CRC_INIT_CCITT = 16'hFFFF;

    localparam int CRC_MAX_W  = 32;
    localparam int DATA_MAX_W = 64;

    // Row i = next crc bit i. Column j < CRC_MAX_W is crc bit j,
    // column CRC_MAX_W+k is data bit k.
    typedef logic [CRC_MAX_W-1:0][CRC_MAX_W+DATA_MAX_W-1:0] crc_mat_t;

    // The step is linear, so each column is the serial LFSR response to a
    // one-hot input. Data is shifted in from its highest index down.
    function automatic crc_mat_t crc_step_matrix(input logic [CRC_MAX_W-1:0] poly,
                                                 input int cw, input int dw);
        crc_mat_t m;
        logic [CRC_MAX_W-1:0]  c;
        logic [DATA_MAX_W-1:0] d;
        logic                  fb;
        m = '0;
        for (int j = 0; j < CRC_MAX_W + DATA_MAX_W; j++) begin
            c = '0;
            d = '0;
            if (j < cw)
                c[j] = 1'b1;
            else if (j >= CRC_MAX_W && (j - CRC_MAX_W) < dw)
                d[j - CRC_MAX_W] = 1'b1;
            for (int b = DATA_MAX_W - 1; b >= 0; b--) begin
                if (b < dw) begin
                    fb = c[cw-1] ^ d[b];
                    c  = {c[CRC_MAX_W-2:0], 1'b0};
                    if (fb)
                        c = c ^ poly;
                end
            end
            for (int i = 0; i < CRC_MAX_W; i++)
                m[i][j] = (i < cw) ? c[i] : 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/c_crc_step.sv
// One-cycle CRC advance over a full data word, as a constant GF(2) matrix.
module c_crc_step
    import c_crc_pkg::*;
#(
    parameter int                   data_width = 8,
    parameter int                   crc_width  = 16,
    parameter logic [crc_width-1:0] crc_poly   = CRC_POLY_CCITT
) (
    input  logic [crc_width-1:0]  crc_cur,
    input  logic [data_width-1:0] data,
    output logic [crc_width-1:0]  crc_nxt
);

    localparam crc_mat_t STEP_M =
        crc_step_matrix(CRC_MAX_W'(crc_poly), crc_width, data_width);

    always_comb begin
        crc_nxt = '0;
        for (int i = 0; i < crc_width; i++) begin
            for (int j = 0; j < crc_width; j++)
                crc_nxt[i] = crc_nxt[i] ^ (STEP_M[i][j] & crc_cur[j]);
            for (int k = 0; k < data_width; k++)
                crc_nxt[i] = crc_nxt[i] ^ (STEP_M[i][CRC_MAX_W+k] & data[k]);
        end
    end

endmodule

// File: rtl/c_crc_check_seq.sv
// Receive-side CRC checker for flit-serialized frames: folds each flit into a
// running CRC and reports pass/fail on the tail plus framing violations.
module c_crc_check_seq
    import c_crc_pkg::*;
#(
    parameter int                   data_width = 8,
    parameter int                   crc_width  = 16,
    parameter logic [crc_width-1:0] crc_poly   = CRC_POLY_CCITT,
    parameter logic [crc_width-1:0] crc_init   = CRC_INIT_CCITT,
    parameter int                   max_flits  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flit_valid_in,
    input  logic                  flit_head_in,
    input  logic                  flit_tail_in,
    input  logic [data_width-1:0] flit_data_in,
    input  logic [crc_width-1:0]  crc_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  error_out,
    output logic                  frame_err_out,
    output logic [crc_width-1:0]  crc_out
);

    localparam int CNT_W = $clog2(max_flits + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(max_flits - 1);

    crc_state_e            state_q;
    logic [crc_width-1:0]  crc_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [crc_width-1:0]  crc_base;
    logic [crc_width-1:0]  crc_nxt;

    // A head always restarts from the init value, even when abandoning a frame.
    assign crc_base = flit_head_in ? crc_init : crc_q;

    c_crc_step #(
        .data_width (data_width),
        .crc_width  (crc_width),
        .crc_poly   (crc_poly)
    ) u_step (
        .crc_cur (crc_base),
        .data    (flit_data_in),
        .crc_nxt (crc_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            crc_q         <= crc_init;
            cnt_q         <= '0;
            done_out      <= 1'b0;
            error_out     <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            done_out      <= 1'b0;
            error_out     <= 1'b0;
            frame_err_out <= 1'b0;
            if (flit_valid_in) begin
                if (flit_head_in) begin
                    if (state_q == BUSY)
                        frame_err_out <= 1'b1;
                    if (flit_tail_in) begin
                        crc_q     <= crc_nxt;
                        done_out  <= 1'b1;
                        error_out <= (crc_nxt != crc_in);
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                    end else if (max_flits == 1) begin
                        frame_err_out <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= IDLE;
                    end else begin
                        crc_q   <= crc_nxt;
                        cnt_q   <= CNT_W'(1);
                        state_q <= BUSY;
                    end
                end else if (state_q == IDLE) begin
                    frame_err_out <= 1'b1;
                end else if (flit_tail_in) begin
                    crc_q     <= crc_nxt;
                    done_out  <= 1'b1;
                    error_out <= (crc_nxt != crc_in);
                    cnt_q     <= '0;
                    state_q   <= IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // No room left for a tail: drop the frame, keep the CRC.
                    frame_err_out <= 1'b1;
                    cnt_q         <= '0;
                    state_q       <= IDLE;
                end else begin
                    crc_q <= crc_nxt;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign busy_out = (state_q == BUSY);
    assign crc_out  = crc_q;

endmodule

// File: tb/tb_c_crc_check_seq.sv
// Randomized and directed bench: a default checker and a max_flits=4 checker
// share stimulus and are compared each cycle against a frame-level model.
module tb_c_crc_check_seq;

    typedef byte unsigned bq_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        flit_valid_in, flit_head_in, flit_tail_in;
    logic [7:0]  flit_data_in;
    logic [15:0] crc_in;

    logic        busy0, done0, err0, ferr0;
    logic [15:0] crc0;
    logic        busy1, done1, err1, ferr1;
    logic [15:0] crc1;

    wire  [19:0] obs [2];
    assign obs[0] = {busy0, done0, err0, ferr0, crc0};
    assign obs[1] = {busy1, done1, err1, ferr1, crc1};

    logic [19:0] e [2];
    bit          m_open [2];
    logic [15:0] m_crc [2];
    bq_t         q0, q1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    c_crc_check_seq dut (
        .clk(clk), .reset(reset), .flit_valid_in(flit_valid_in),
        .flit_head_in(flit_head_in), .flit_tail_in(flit_tail_in),
        .flit_data_in(flit_data_in), .crc_in(crc_in),
        .busy_out(busy0), .done_out(done0), .error_out(err0),
        .frame_err_out(ferr0), .crc_out(crc0)
    );

    c_crc_check_seq #(.max_flits(4)) dut4 (
        .clk(clk), .reset(reset), .flit_valid_in(flit_valid_in),
        .flit_head_in(flit_head_in), .flit_tail_in(flit_tail_in),
        .flit_data_in(flit_data_in), .crc_in(crc_in),
        .busy_out(busy1), .done_out(done1), .error_out(err1),
        .frame_err_out(ferr1), .crc_out(crc1)
    );

    // CRC-16/CCITT-FALSE over a byte sequence, MSB of each byte first.
    function automatic logic [15:0] crc_of(input bq_t q);
        logic [15:0] c = 16'hFFFF;
        foreach (q[n]) begin
            c = c ^ {q[n], 8'h00};
            for (int b = 0; b < 8; b++)
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    task automatic model_one(input int i, input int maxf, input bit h, input bit t,
                             input logic [7:0] d, input logic [15:0] ci);
        bq_t q;
        bit  dn = 1'b0, er = 1'b0, fe = 1'b0;
        if (i == 0) q = q0; else q = q1;
        if (h) begin
            if (m_open[i]) fe = 1'b1;
            q.delete();
            q.push_back(d);
            if (t) begin
                m_crc[i] = crc_of(q); dn = 1'b1; er = (m_crc[i] != ci); m_open[i] = 1'b0;
            end else if (maxf == 1) begin
                fe = 1'b1; m_open[i] = 1'b0;
            end else begin
                m_crc[i] = crc_of(q); m_open[i] = 1'b1;
            end
        end else if (!m_open[i]) begin
            fe = 1'b1;
        end else begin
            q.push_back(d);
            if (t) begin
                m_crc[i] = crc_of(q); dn = 1'b1; er = (m_crc[i] != ci); m_open[i] = 1'b0;
            end else if (q.size() >= maxf) begin
                fe = 1'b1; m_open[i] = 1'b0;
            end else begin
                m_crc[i] = crc_of(q);
            end
        end
        if (i == 0) q0 = q; else q1 = q;
        e[i] = {m_open[i], dn, er, fe, m_crc[i]};
    endtask

    task automatic drive(input bit rst, input bit v, input bit h, input bit t,
                         input logic [7:0] d, input logic [15:0] ci);
        @(negedge clk);
        reset = rst; flit_valid_in = v; flit_head_in = h; flit_tail_in = t;
        flit_data_in = d; crc_in = ci;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_open[i] = 1'b0; m_crc[i] = 16'hFFFF;
                e[i] = {4'b0000, 16'hFFFF};
            end else begin
                e[i] = {m_open[i], 3'b000, m_crc[i]};
            end
        end
        if (rst) begin
            q0.delete(); q1.delete();
        end else if (v) begin
            model_one(0, 64, h, t, d, ci);
            model_one(1, 4, h, t, d, ci);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 8'h00, 16'h0000);
        drive(1, 1, 1, 0, 8'h55, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (obs[i] !== {4'b0000, 16'hFFFF}) begin
                n_fail++;
                $display("FAIL reset inst%0d: got %h, expected %h", i, obs[i], {4'b0000, 16'hFFFF});
            end
        end
        drive(0, 0, 0, 0, 8'h00, 16'h0000);
    endtask

    task automatic test_good_frame(input logic [15:0] ci, input bit want_err);
        for (int k = 0; k < 9; k++) begin
            drive(0, 1, k == 0, k == 8, 8'(8'h31 + k), ci);
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (obs[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL frame9[%0d] inst%0d: got %h, expected %h", k, i, obs[i], e[i]);
                end
            end
        end
        n_chk++;
        if ({busy0, done0, err0, crc0} !== {1'b0, 1'b1, want_err, 16'h29B1}) begin
            n_fail++;
            $display("FAIL frame9_result: got busy=%b done=%b err=%b crc=%h, expected 0 1 %b 29b1",
                     busy0, done0, err0, crc0, want_err);
        end
        drive(0, 0, 0, 0, 8'($urandom), 16'($urandom));
        n_chk++;
        if (obs[0] !== e[0]) begin
            n_fail++;
            $display("FAIL frame9_after: got %h, expected %h", obs[0], e[0]);
        end
    endtask

    task automatic test_single_back_to_back();
        bq_t one;
        int  n_done = 0, n_ferr = 0, n_busy = 0;
        one.push_back(8'h31);
        for (int k = -1; k < 9; k++) begin
            if (k < 0) drive(0, 1, 1, 1, 8'h31, crc_of(one));
            else       drive(0, 1, k == 0, k == 8, 8'(8'h31 + k), 16'h29B1);
            n_done += int'(done0); n_ferr += int'(ferr0);
            if (k < 0) n_busy += int'(busy0);
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (obs[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL single_b2b[%0d] inst%0d: got %h, expected %h", k, i, obs[i], e[i]);
                end
            end
        end
        n_chk++;
        if (n_done != 2 || n_ferr != 0 || n_busy != 0) begin
            n_fail++;
            $display("FAIL single_b2b_counts: got done=%0d ferr=%0d busy=%0d, expected 2 0 0",
                     n_done, n_ferr, n_busy);
        end
    endtask

    task automatic test_framing();
        bq_t f2;
        logic [15:0] c_before;
        for (int k = 0; k < 3; k++) f2.push_back(8'(8'hA0 + k));
        c_before = crc0;
        drive(0, 1, 0, 0, 8'h77, 16'h0000);
        n_chk++;
        if ({ferr0, done0, crc0} !== {1'b1, 1'b0, c_before}) begin
            n_fail++;
            $display("FAIL idle_body: got ferr=%b done=%b crc=%h, expected 1 0 %h", ferr0, done0, crc0, c_before);
        end
        drive(0, 1, 1, 0, 8'h10, 16'h0);
        drive(0, 1, 0, 0, 8'h11, 16'h0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, k == 0, k == 2, f2[k], crc_of(f2));
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (obs[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL second_head[%0d] inst%0d: got %h, expected %h", k, i, obs[i], e[i]);
                end
            end
        end
    endtask

    task automatic test_overlength();
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, k == 0, k == 5, 8'($urandom), 16'($urandom));
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (obs[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL overlength[%0d] inst%0d: got %h, expected %h", k, i, obs[i], e[i]);
                end
            end
            if (k == 3) begin
                n_chk++;
                if ({ferr1, busy1} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL overlength_cut: got ferr=%b busy=%b, expected 1 0", ferr1, busy1);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 0; k < 9; k++) begin
            drive(k == 4, 1, k == 0, k == 8, 8'(8'h31 + k), 16'h29B1);
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (obs[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL reset_mid[%0d] inst%0d: got %h, expected %h", k, i, obs[i], e[i]);
                end
            end
            if (k == 4) begin
                n_chk++;
                if ({busy0, done0, crc0} !== {1'b0, 1'b0, 16'hFFFF}) begin
                    n_fail++;
                    $display("FAIL reset_mid_state: got busy=%b done=%b crc=%h, expected 0 0 ffff",
                             busy0, done0, crc0);
                end
            end
        end
        test_good_frame(16'h29B1, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 60; f++) begin
            bq_t fr;
            int  len = $urandom_range(1, 10);
            bit  good = ($urandom_range(0, 3) != 0);
            logic [15:0] ci;
            for (int k = 0; k < len; k++) fr.push_back(8'($urandom));
            ci = good ? crc_of(fr) : 16'($urandom);
            for (int k = 0; k < len + 2; k++) begin
                if (k < len)
                    drive(0, 1, k == 0, k == len - 1, fr[k], ci);
                else if ($urandom_range(0, 9) == 0)
                    drive(0, 1, 1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom));
                else if (k == len && $urandom_range(0, 1) == 0)
                    drive(0, 0, 1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom));
                else
                    continue;
                for (int i = 0; i < 2; i++) begin
                    n_chk++;
                    if (obs[i] !== e[i]) begin
                        n_fail++;
                        $display("FAIL random[%0d.%0d] inst%0d: got %h, expected %h", f, k, i, obs[i], e[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; flit_valid_in = 1'b0; flit_head_in = 1'b0; flit_tail_in = 1'b0;
        flit_data_in = '0; crc_in = '0;
        test_reset();
        test_good_frame(16'h29B1, 1'b0);
        test_good_frame(16'h29B0, 1'b1);
        test_single_back_to_back();
        test_framing();
        test_overlength();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
